// File: rtl/ap_hs_initiator_if.sv
// Signal bundle between ap_hs_initiator, the command/result fabric and one ap_ctrl_hs kernel.
// master: the initiator's view. slave: the view of the fabric plus kernel that surround it.
interface ap_hs_initiator_if #(
  parameter int DW = 32
);
  // Command port
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_in1;
  logic [DW-1:0] cmd_in2;
  logic [DW-1:0] cmd_in3;
  logic [DW-1:0] cmd_in4;
  logic [DW-1:0] cmd_in5;
  logic [DW-1:0] cmd_in6;

  // Kernel ap_ctrl_hs port
  logic          k_start;
  logic          k_ready;
  logic          k_done;
  logic          k_idle;
  logic [DW-1:0] k_in1;
  logic [DW-1:0] k_in2;
  logic [DW-1:0] k_in3;
  logic [DW-1:0] k_in4;
  logic [DW-1:0] k_in5;
  logic [DW-1:0] k_in6;
  logic [DW-1:0] k_return;

  // Result port
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_err;

  modport master (
    input  cmd_valid, cmd_in1, cmd_in2, cmd_in3, cmd_in4, cmd_in5, cmd_in6,
    output cmd_ready,
    output k_start, k_in1, k_in2, k_in3, k_in4, k_in5, k_in6,
    input  k_ready, k_done, k_idle, k_return,
    output res_valid, res_data, res_err,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_in1, cmd_in2, cmd_in3, cmd_in4, cmd_in5, cmd_in6,
    input  cmd_ready,
    input  k_start, k_in1, k_in2, k_in3, k_in4, k_in5, k_in6,
    output k_ready, k_done, k_idle, k_return,
    input  res_valid, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/ap_hs_initiator.sv
// ap_ctrl_hs initiator: takes six-operand commands, sequences one kernel and returns its result.
// Optional watchdog enabled by defining AP_HS_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module ap_hs_initiator #(
  parameter int DW             = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  ap_hs_initiator_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             capture;
  logic             expire;
  logic             complete;
  logic             tmo_hit;
  logic [DW-1:0]    opnd_q [6];
  logic [DW-1:0]    res_data_q;
  logic [CNT_W-1:0] txn_count_q;

  // State register
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic. Done is checked before ready so an early done in
  // ISSUE counts as both, and a done in the same cycle as the watchdog wins.
  // NOTE: every output of a combinational process gets a default first,
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.k_done) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          expire  = 1'b1;
          state_d = RESP;
        end else if (bus.k_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.k_done) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register only, so k_start never follows
  // k_ready combinationally and is low outside ISSUE.
  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.k_start   = (state_q == ISSUE);
    bus.res_valid = (state_q == RESP);
    busy          = (state_q != IDLE);
  end

  assign complete = (state_q == RESP) && bus.res_ready;

  // Operands stay put from acceptance until the next accepted command.
  // NOTE: this small operand array is reset on purpose: the kernel inputs
  // must read as zero out of reset. Large storage arrays would not be reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < 6; i++) opnd_q[i] <= '0;
    end else if (accept) begin
      opnd_q[0] <= bus.cmd_in1;
      opnd_q[1] <= bus.cmd_in2;
      opnd_q[2] <= bus.cmd_in3;
      opnd_q[3] <= bus.cmd_in4;
      opnd_q[4] <= bus.cmd_in5;
      opnd_q[5] <= bus.cmd_in6;
    end
  end

  assign bus.k_in1 = opnd_q[0];
  assign bus.k_in2 = opnd_q[1];
  assign bus.k_in3 = opnd_q[2];
  assign bus.k_in4 = opnd_q[3];
  assign bus.k_in5 = opnd_q[4];
  assign bus.k_in6 = opnd_q[5];

  // Result register: loaded only on the edge that ends a done (or watchdog)
  // cycle, so it is stable for the whole time RESP is held.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)    res_data_q <= '0;
    else if (capture) res_data_q <= bus.k_return;
    else if (expire)  res_data_q <= '0;
  end

  assign bus.res_data = res_data_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)     txn_count_q <= '0;
    else if (complete) txn_count_q <= txn_count_q + CNT_W'(1);
  end

  assign txn_count = txn_count_q;

`ifdef AP_HS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          res_err_q;
  logic          timeout_err_q;
  logic          waiting;
  logic          unused_ok;

  assign waiting = (state_q == ISSUE) || (state_q == WAIT_DONE);

  // Counts cycles spent waiting on the kernel; fires on the last permitted one.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)    tmo_cnt_q <= '0;
    else if (accept)  tmo_cnt_q <= '0;
    else if (waiting) tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end

  assign tmo_hit = waiting && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else if (capture) begin
      res_err_q     <= 1'b0;
    end else if (expire) begin
      res_err_q     <= 1'b1;
      timeout_err_q <= 1'b1;
    end
  end

  assign bus.res_err  = res_err_q;
  assign timeout_err  = timeout_err_q;
  assign unused_ok    = bus.k_idle;
`else
  localparam logic [31:0] TMO_VEC = TIMEOUT_CYCLES;

  logic unused_ok;

  assign tmo_hit      = 1'b0;
  assign bus.res_err  = 1'b0;
  assign timeout_err  = 1'b0;
  assign unused_ok    = &{bus.k_idle, TMO_VEC[0]};
`endif

endmodule

// File: doc/ap_hs_initiator.md
# ap_hs_initiator

Initiator for the `ap_ctrl_hs` block-level handshake used by the team's HLS-generated arithmetic kernels, which take six 32-bit operands and return one 32-bit result. It accepts operand sets through a valid/ready command port and drives them into one attached kernel. It sequences `ap_start` against `ap_ready`/`ap_done`, captures `ap_return` and presents it on a valid/ready result port. It sits between the test/DMA fabric and a kernel instance, so kernels never see raw fabric timing.

## Interface
Parameters:
- `DW`, 32: operand and result width.
- `CNT_W`, 16: width of the transaction counter.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles. Used only when `AP_HS_TIMEOUT_EN` is defined.

Ports:
- `ap_clk` in 1: clock; all logic rises on its positive edge.
- `ap_rst_n` in 1: reset, asynchronous assert, active-low; deassert synchronised externally.
- `cmd_valid` in 1: operand set available.
- `cmd_ready` out 1: initiator can accept an operand set.
- `cmd_in1`..`cmd_in6` in DW each: operand set.
- `k_start` out 1: drives the kernel's `ap_start`.
- `k_ready` in 1: kernel's `ap_ready`.
- `k_done` in 1: kernel's `ap_done`.
- `k_idle` in 1: kernel's `ap_idle`; status only.
- `k_in1`..`k_in6` out DW each: operands driven to the kernel.
- `k_return` in DW: kernel's `ap_return`, valid only while `k_done`=1.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out DW: captured result.
- `res_err` out 1: the result was produced by a timeout; 0 when `AP_HS_TIMEOUT_EN` is undefined.
- `busy` out 1: FSM is not in IDLE.
- `txn_count` out CNT_W: count of completed result handshakes. Wraps modulo 2^CNT_W.
- `timeout_err` out 1: sticky timeout flag, cleared only by reset; tied to 0 when `AP_HS_TIMEOUT_EN` is undefined.

## Operation
States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, register all six operands into `k_in*` and go to ISSUE.
- ISSUE:
  - `k_start`=1.
  - If `k_ready`=1 and `k_done`=1: capture `k_return` into `res_data`, go to RESP.
  - If `k_ready`=1 and `k_done`=0: go to WAIT_DONE.
  - If `k_done`=1 and `k_ready`=0 (early done): treat as both, capture, go to RESP.
- WAIT_DONE:
  - `k_start`=0.
  - On `k_done`=1, capture `k_return` and go to RESP.
- RESP:
  - `res_valid`=1.
  - On `res_ready`, increment `txn_count` and return to IDLE.
- `k_in*` hold their value from acceptance until the next accepted command. This meets the kernel rule that inputs stay stable until `ap_ready`.
- `k_start` is registered and decoded only from state, never combinationally from `k_ready`.
- `k_start` is low in every state other than ISSUE. This guarantees the kernel returns to its idle state and is not re-triggered.
- `cmd_ready`=1 only in IDLE; there is no command/result overlap.
- `res_data` and `res_err` stay stable while `res_valid`=1 and `res_ready`=0.
- Reset (asynchronous, at any point including mid-transaction):
  - FSM to IDLE.
  - `k_start`, `res_valid`, `res_err`, `timeout_err` = 0.
  - `res_data`, `k_in*`, `txn_count` = 0.
  - The kernel must be reset alongside this block; the initiator does not drain an in-flight kernel.
- `k_idle` is not used for sequencing.

## Timing
- Command accepted on cycle T (`cmd_valid`&`cmd_ready`).
- T+1: `k_start`=1 and `k_in*` are valid.
- ISSUE lasts until the cycle with `k_ready`=1, inclusive. `k_start`=0 on the following cycle.
- For a three-state kernel (start accepted at T+1, done/ready at T+3):
  - `k_start` is high T+1..T+3.
  - `res_valid`=1 from T+4.
  - Next `cmd_ready` is on the cycle after `res_ready` is sampled high.
- The `k_return` capture happens on the edge ending the `k_done` cycle.
- Back-to-back throughput is one transaction per kernel latency + 2 cycles, provided `res_ready` is held at 1.

## Configuration
- `AP_HS_TIMEOUT_EN` defined:
  - A counter runs in ISSUE and WAIT_DONE and clears on entering ISSUE.
  - When it reaches `TIMEOUT_CYCLES`: drop `k_start`, set `res_data`=0, `res_err`=1 and `timeout_err`=1, and go to RESP.
  - A `k_done` arriving later is ignored.
- `AP_HS_TIMEOUT_EN` undefined:
  - No counter is built; the initiator waits indefinitely in ISSUE/WAIT_DONE.
  - `res_err` and `timeout_err` are constant 0.

## Test plan
- Kernel model with done/ready at start+2; cmd in1=7, in5=3, others 0; `res_ready`=1 → `k_start` high exactly 3 cycles, `res_data`=kernel output (e.g. 11), `res_valid` at T+4, `txn_count`=1.
- Model raises `k_ready` at start+1 and `k_done` at start+4 → `k_start` low from start+2, capture only at `k_done`, `k_in*` unchanged throughout.
- `res_ready` held 0 for 10 cycles after `res_valid` → `res_data` stable, `cmd_ready`=0, `k_start`=0; release → IDLE in 1 cycle, count increments once.
- Reset pulsed low during WAIT_DONE → all outputs at reset values immediately, without waiting for a clock edge; new command after release completes normally.
- `AP_HS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, kernel never asserts done → `res_valid` with `res_err`=1, `res_data`=0, `timeout_err` sticky; a late `k_done` has no effect.
- Preload `txn_count` to 2^CNT_W−1 via 65535 transactions (CNT_W=16) → next completion wraps it to 0.
